// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared defaults, pointer-width helper and error-flag bit positions
package sync_fifo_pkg;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_DEPTH = 64;
   typedef enum logic {OVF = 1'b0, UDF = 1'b1} err_bit_e;
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: DEPTH x DATA_WIDTH storage, synchronous write, asynchronous read
module sync_fifo_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH = 64,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_pm.sv
// sync_fifo_pm: single-clock FIFO with thresholds and sticky errors; define SYNC_FIFO_FWFT_EN for first-word-fall-through reads
module sync_fifo_pm
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   localparam int AW = $clog2(DEPTH),
   localparam int PW = ptr_w(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty,
   input  logic [PW-1:0]         af_thresh,
   input  logic [PW-1:0]         ae_thresh,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [PW-1:0]         count,
   output logic [PW-1:0]         margin,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  err_clr
);
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d, ram_rdata;
   logic [1:0] err_q, err_d;
   logic wr_acc, rd_acc;
`ifdef SYNC_FIFO_FWFT_EN
   logic valid_q, valid_d, load;
   // count spans the RAM plus the prefetched head word in the output stage
   assign count = wr_ptr_q - rd_ptr_q + PW'(valid_q);
   assign empty = !valid_q;
`else
   assign count = wr_ptr_q - rd_ptr_q;
   assign empty = count == '0;
`endif
   assign full = count == PW'(DEPTH);
   assign margin = PW'(DEPTH) - count;
   assign almost_full = count >= af_thresh;
   assign almost_empty = count <= ae_thresh;
   assign data_out = dout_q;
   assign overflow = err_q[OVF];
   assign underflow = err_q[UDF];
   always_comb begin
      wr_acc = wr_en && !full;
      rd_acc = rd_en && !empty;
      wr_ptr_d = wr_ptr_q + PW'(wr_acc);
`ifdef SYNC_FIFO_FWFT_EN
      load = (wr_ptr_q != rd_ptr_q) && (!valid_q || rd_acc);
      valid_d = load || (valid_q && !rd_acc);
      rd_ptr_d = rd_ptr_q + PW'(load);
      dout_d = load ? ram_rdata : dout_q;
`else
      rd_ptr_d = rd_ptr_q + PW'(rd_acc);
      dout_d = rd_acc ? ram_rdata : dout_q;
`endif
      err_d[OVF] = (wr_en && full) || (err_q[OVF] && !err_clr);
      err_d[UDF] = (rd_en && empty) || (err_q[UDF] && !err_clr);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         dout_q <= '0;
         err_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         dout_q <= dout_d;
         err_q <= err_d;
      end
`ifdef SYNC_FIFO_FWFT_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) valid_q <= 1'b0;
      else valid_q <= valid_d;
`endif
   sync_fifo_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_ram (
      .clk  (clk),
      .we   (wr_acc),
      .waddr(wr_ptr_q[AW-1:0]),
      .wdata(data_in),
      .raddr(rd_ptr_q[AW-1:0]),
      .rdata(ram_rdata)
   );
endmodule

// File: tb/tb_sync_fifo_pm.sv
// tb_sync_fifo_pm: directed checks of a 64-deep and a 4-deep sync_fifo_pm
module tb_sync_fifo_pm;
   logic clk = 1'b0;
   logic rst_n;
   logic wr_en, rd_en, err_clr;
   logic [31:0] din, dout;
   logic full, empty, af, ae, ovf, udf;
   logic [6:0] aft, aet, cnt, mgn;
   logic b_wr, b_rd, b_clr;
   logic [31:0] b_din, b_dout;
   logic b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
   logic [2:0] b_aft, b_aet, b_cnt, b_mgn;
   int vectors = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sync_fifo_pm #(.DATA_WIDTH(32), .DEPTH(64)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(din), .rd_en(rd_en),
      .data_out(dout), .full(full), .empty(empty), .af_thresh(aft), .ae_thresh(aet),
      .almost_full(af), .almost_empty(ae), .count(cnt), .margin(mgn),
      .overflow(ovf), .underflow(udf), .err_clr(err_clr)
   );

   sync_fifo_pm #(.DATA_WIDTH(32), .DEPTH(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .wr_en(b_wr), .data_in(b_din), .rd_en(b_rd),
      .data_out(b_dout), .full(b_full), .empty(b_empty), .af_thresh(b_aft), .ae_thresh(b_aet),
      .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt), .margin(b_mgn),
      .overflow(b_ovf), .underflow(b_udf), .err_clr(b_clr)
   );

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic fill(input int base);
      for (int i = 0; i < 64; i++) begin
         wr_en = 1'b1;
         din = 32'(base + i);
         tick();
      end
      wr_en = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick();
      tick();
      vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
      vectors++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
      vectors++; if (cnt !== 7'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cnt); end
      vectors++; if (mgn !== 7'd64) begin errors++; $display("FAIL reset_margin got %0d exp 64", mgn); end
      vectors++; if (ae !== 1'b1 || af !== 1'b0) begin errors++; $display("FAIL reset_ae_af got %b%b exp 10", ae, af); end
      vectors++; if (ovf !== 1'b0 || udf !== 1'b0) begin errors++; $display("FAIL reset_err got %b%b exp 00", ovf, udf); end
      vectors++; if (dout !== 32'd0) begin errors++; $display("FAIL reset_dout got %0h exp 0", dout); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_fill_drain;
      fill(0);
      vectors++; if (full !== 1'b1) begin errors++; $display("FAIL fd_full got %b exp 1", full); end
      vectors++; if (cnt !== 7'd64) begin errors++; $display("FAIL fd_count got %0d exp 64", cnt); end
      vectors++; if (mgn !== 7'd0) begin errors++; $display("FAIL fd_margin got %0d exp 0", mgn); end
      wr_en = 1'b1;
      din = 32'd99;
      tick();
      wr_en = 1'b0;
      vectors++; if (ovf !== 1'b1) begin errors++; $display("FAIL fd_overflow got %b exp 1", ovf); end
      vectors++; if (cnt !== 7'd64) begin errors++; $display("FAIL fd_ovf_count got %0d exp 64", cnt); end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      for (int i = 0; i < 64; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
         vectors++; if (dout !== 32'(i)) begin errors++; $display("FAIL fd_data[%0d] got %0h exp %0h", i, dout, i); end
         rd_en = 1'b1;
         tick();
`else
         rd_en = 1'b1;
         tick();
         vectors++; if (dout !== 32'(i)) begin errors++; $display("FAIL fd_data[%0d] got %0h exp %0h", i, dout, i); end
`endif
      end
      rd_en = 1'b0;
      vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL fd_empty got %b exp 1", empty); end
      vectors++; if (mgn !== 7'd64) begin errors++; $display("FAIL fd_drain_margin got %0d exp 64", mgn); end
      vectors++; if (udf !== 1'b0) begin errors++; $display("FAIL fd_underflow got %b exp 0", udf); end
   endtask

   task automatic test_thresholds;
      for (int i = 1; i <= 48; i++) begin
         wr_en = 1'b1;
         din = 32'(i);
         tick();
         vectors++; if (af !== (i >= 48)) begin errors++; $display("FAIL th_af[%0d] got %b exp %b", i, af, i >= 48); end
         vectors++; if (ae !== (i <= 8)) begin errors++; $display("FAIL th_ae[%0d] got %b exp %b", i, ae, i <= 8); end
      end
      wr_en = 1'b0;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      vectors++; if (af !== 1'b0) begin errors++; $display("FAIL th_af_after_read got %b exp 0", af); end
      vectors++; if (cnt !== 7'd47) begin errors++; $display("FAIL th_count got %0d exp 47", cnt); end
      rd_en = 1'b1;
      for (int i = 0; i < 47; i++) tick();
      rd_en = 1'b0;
      vectors++; if (cnt !== 7'd0 || empty !== 1'b1) begin errors++; $display("FAIL th_drain got cnt=%0d empty=%b exp 0/1", cnt, empty); end
   endtask

   task automatic test_simultaneous;
      fill(100);
      wr_en = 1'b1;
      rd_en = 1'b1;
      din = 32'hdead;
      tick();
      wr_en = 1'b0;
      rd_en = 1'b0;
      vectors++; if (cnt !== 7'd63) begin errors++; $display("FAIL sim_full_count got %0d exp 63", cnt); end
      vectors++; if (ovf !== 1'b1) begin errors++; $display("FAIL sim_full_ovf got %b exp 1", ovf); end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      for (int i = 0; i < 63; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
         vectors++; if (dout !== 32'(101 + i)) begin errors++; $display("FAIL sim_data[%0d] got %0h exp %0h", i, dout, 101 + i); end
         rd_en = 1'b1;
         tick();
`else
         rd_en = 1'b1;
         tick();
         vectors++; if (dout !== 32'(101 + i)) begin errors++; $display("FAIL sim_data[%0d] got %0h exp %0h", i, dout, 101 + i); end
`endif
      end
      rd_en = 1'b0;
      vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL sim_empty got %b exp 1", empty); end
      wr_en = 1'b1;
      rd_en = 1'b1;
      din = 32'h55;
      tick();
      wr_en = 1'b0;
      rd_en = 1'b0;
      vectors++; if (cnt !== 7'd1) begin errors++; $display("FAIL sim_empty_count got %0d exp 1", cnt); end
      vectors++; if (udf !== 1'b1) begin errors++; $display("FAIL sim_empty_udf got %b exp 1", udf); end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      vectors++; if (udf !== 1'b0) begin errors++; $display("FAIL sim_udf_clear got %b exp 0", udf); end
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      vectors++; if (dout !== 32'h55) begin errors++; $display("FAIL sim_data_55 got %0h exp 55", dout); end
      vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL sim_final_empty got %b exp 1", empty); end
   endtask

   task automatic test_err_clr;
      fill(200);
      wr_en = 1'b1;
      err_clr = 1'b1;
      din = 32'hbeef;
      tick();
      wr_en = 1'b0;
      vectors++; if (ovf !== 1'b1) begin errors++; $display("FAIL ec_set_wins got %b exp 1", ovf); end
      vectors++; if (cnt !== 7'd64) begin errors++; $display("FAIL ec_count got %0d exp 64", cnt); end
      tick();
      err_clr = 1'b0;
      vectors++; if (ovf !== 1'b0) begin errors++; $display("FAIL ec_clear got %b exp 0", ovf); end
   endtask

   task automatic test_wrap;
      logic [31:0] v;
      for (int i = 0; i < 200; i++) begin
         v = 32'(i * 7 + 3);
         b_wr = 1'b1;
         b_din = v;
         tick();
         b_wr = 1'b0;
         vectors++; if (b_cnt !== 3'd1) begin errors++; $display("FAIL wrap_count[%0d] got %0d exp 1", i, b_cnt); end
`ifdef SYNC_FIFO_FWFT_EN
         tick();
`endif
         b_rd = 1'b1;
         tick();
         b_rd = 1'b0;
         vectors++; if (b_dout !== v) begin errors++; $display("FAIL wrap_data[%0d] got %0h exp %0h", i, b_dout, v); end
         vectors++; if (b_cnt !== 3'd0 || b_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty[%0d] got cnt=%0d empty=%b exp 0/1", i, b_cnt, b_empty); end
      end
      vectors++; if (b_ovf !== 1'b0 || b_udf !== 1'b0) begin errors++; $display("FAIL wrap_err got %b%b exp 00", b_ovf, b_udf); end
      for (int i = 0; i < 5; i++) begin
         b_wr = 1'b1;
         b_din = 32'(i);
         tick();
      end
      b_wr = 1'b0;
      vectors++; if (b_cnt !== 3'd4 || b_full !== 1'b1 || b_ovf !== 1'b1) begin errors++; $display("FAIL wrap_full got cnt=%0d full=%b ovf=%b exp 4/1/1", b_cnt, b_full, b_ovf); end
   endtask

   task automatic test_reset_mid;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 11; i++) begin
         wr_en = 1'b1;
         din = 32'(16 + i);
         tick();
      end
      wr_en = 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
      tick();
`endif
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      vectors++; if (cnt !== 7'd10 || dout === 32'd0) begin errors++; $display("FAIL rm_pre got cnt=%0d dout=%0h exp 10/nonzero", cnt, dout); end
      rst_n = 1'b0;
      #1;
      vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL rm_empty got %b exp 1", empty); end
      vectors++; if (cnt !== 7'd0) begin errors++; $display("FAIL rm_count got %0d exp 0", cnt); end
      vectors++; if (dout !== 32'd0) begin errors++; $display("FAIL rm_dout got %0h exp 0", dout); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_latency;
      wr_en = 1'b1;
      din = 32'ha5;
      tick();
      wr_en = 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
      vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL lat_prefetch_empty got %b exp 1", empty); end
      tick();
      vectors++; if (empty !== 1'b0 || dout !== 32'ha5) begin errors++; $display("FAIL lat_fwft got empty=%b dout=%0h exp 0/a5", empty, dout); end
`else
      vectors++; if (empty !== 1'b0 || dout !== 32'd0) begin errors++; $display("FAIL lat_write got empty=%b dout=%0h exp 0/0", empty, dout); end
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      vectors++; if (dout !== 32'ha5 || empty !== 1'b1) begin errors++; $display("FAIL lat_read got dout=%0h empty=%b exp a5/1", dout, empty); end
      tick();
      vectors++; if (dout !== 32'ha5) begin errors++; $display("FAIL lat_hold got %0h exp a5", dout); end
`endif
   endtask

   initial begin
      wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; din = '0;
      aft = 7'd48; aet = 7'd8;
      b_wr = 1'b0; b_rd = 1'b0; b_clr = 1'b0; b_din = '0;
      b_aft = 3'd4; b_aet = 3'd0;
      test_reset();
      test_fill_drain();
      test_thresholds();
      test_simultaneous();
      test_err_clr();
      test_wrap();
      test_reset_mid();
      test_latency();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/sync_fifo_pm.md
# sync_fifo_pm

Parametrised single-clock FIFO for the MCDF slave channels, the next generation of the 64-deep slave FIFO. Width and depth are parameters, and the margin/count outputs are full-width, so a completely empty FIFO reports its true margin of DEPTH. The block adds programmable almost-full/almost-empty flags and sticky overflow/underflow error flags. A compile-time option selects first-word-fall-through (FWFT) read behaviour for the arbiter side.

## Interface
Parameters:
- DATA_WIDTH, 32, data word width (≥1)
- DEPTH, 64, number of entries; power of two, ≥4
- AW (localparam), $clog2(DEPTH), address width; pointers are AW+1 bits

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- rd_en  in  1  read request (FWFT: pop/acknowledge of the head word)
- data_out  out  DATA_WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  no readable word (FWFT: data_out not valid)
- af_thresh  in  AW+1  almost-full threshold, quasi-static
- ae_thresh  in  AW+1  almost-empty threshold, quasi-static
- almost_full  out  1  count ≥ af_thresh
- almost_empty  out  1  count ≤ ae_thresh
- count  out  AW+1  words held, 0..DEPTH
- margin  out  AW+1  DEPTH − count, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- err_clr  in  1  synchronous clear of overflow/underflow

## Operation
- Write is accepted when wr_en && !full. The word is stored at wr_ptr[AW-1:0] and wr_ptr increments by 1, mod 2^(AW+1).
- Read is accepted when rd_en && !empty. rd_ptr increments by 1.
- full and empty are evaluated on the current-cycle state:
  - A write while full is rejected even if a read is accepted in the same cycle.
  - A read while empty is rejected even if a write is accepted in the same cycle.
- Simultaneous accepted read and write leave count unchanged.
- count = wr_ptr − rd_ptr, computed in AW+1 bits. margin = DEPTH − count.
- almost_full, almost_empty, full, empty, count and margin are combinational from registered state and the threshold inputs.
- Sticky error flags:
  - overflow is set on wr_en && full; underflow is set on rd_en && empty.
  - err_clr clears both flags.
  - If a set event and err_clr occur in the same cycle, the set wins.
- A rejected access changes no pointer and no storage.
- Reset values: pointers 0, data_out 0, overflow and underflow 0. Hence empty=1, full=0, count=0, margin=DEPTH, almost_empty=1 (since ae_thresh ≥ 0). almost_full=1 only when af_thresh=0.
- Storage contents are not reset.
- Reset asserted mid-operation discards all contents immediately, with no drain.

## Timing
- Standard mode:
  - data_out updates on the edge that accepts the read and shows the word on the following cycle (1-cycle latency).
  - data_out holds its last value otherwise.
- Write→readable: a word written at edge N clears empty after edge N, so a read can be accepted at edge N+1.
- Flags and count update after the edge of the accepted access; there is no extra pipeline stage.
- Wrap-around: pointers roll from 2^(AW+1)−1 to 0 without disturbing the flags.

## Configuration
- SYNC_FIFO_FWFT_EN defined:
  - The head word is presented on data_out whenever empty=0. rd_en pops it, and the next word, or empty=1, appears the next cycle.
  - A word written into an empty FIFO at edge N appears on data_out, with empty=0, after edge N+1 (one prefetch cycle).
  - Total capacity remains DEPTH; count includes the word in the output stage.
- Not defined: standard mode as described above.
- Port list is identical in both modes.

## Structure
- Package sync_fifo_pkg holds:
  - the width helper function for AW+1;
  - the default DATA_WIDTH and DEPTH constants;
  - the error-flag bit enum (OVF, UDF) shared with the MCDF register block.
- One sub-module, sync_fifo_ram: a DEPTH×DATA_WIDTH storage array with a 1-write/1-read port, synchronous write and asynchronous read address.
- Pointer, flag and FWFT prefetch logic live in the top module.

## Test plan
- Fill/drain, DEPTH=64: write 64 words 0..63 → full=1, count=64, margin=0. One more write → overflow=1 and contents unchanged. Read 64 → data 0..63 in order, empty=1, margin=64.
- Thresholds: af_thresh=48, ae_thresh=8. Write 48 → almost_full asserts after the 48th write and deasserts after the next read. almost_empty deasserts after the 9th write.
- Simultaneous access:
  - at count=64, wr_en and rd_en together → read accepted, write rejected, count=63, overflow=1;
  - at count=0, both together → write accepted, underflow=1, count=1.
- Error clear: err_clr together with a write-while-full → overflow stays 1. err_clr alone next cycle → overflow=0.
- Wrap-around: 200 single write/read pairs through a DEPTH=4 FIFO → data intact, count never exceeds 4.
- Reset mid-operation: assert rst_n=0 with count=10 → same cycle: empty=1, count=0, data_out=0. FWFT build: write 0xA5 to an empty FIFO → data_out=0xA5 and empty=0 two edges later, with no rd_en.
